// File: rtl/spi_fsm_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave control FSM.
//  - spi_state_t : 3-bit FSM state encoding
//  - SPI_BITS    : bits per transaction phase (address phase, data phase)
//  - SPI_CNT_W   : bit-counter width (2**SPI_CNT_W > SPI_BITS)
//  - SPI_READ    : value of the R/W bit that selects a read
//  - is_abortable: states whose cs-driven exit counts as an abort
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int   SPI_BITS  = 8;
  localparam int   SPI_CNT_W = 4;
  localparam logic SPI_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET       = 3'd1,
    GOT       = 3'd2,
    RD_LOAD   = 3'd3,
    RD_SEND   = 3'd4,
    WR_RECV   = 3'd5,
    WR_COMMIT = 3'd6,
    DONE      = 3'd7
  } spi_state_t;

  // GET through WR_COMMIT are mid-transaction; leaving them on cs=1 is an abort.
  // DONE is excluded because cs=1 is its normal exit.
  function automatic logic is_abortable(input spi_state_t s);
    logic v;
    case (s)
      GET, GOT, RD_LOAD, RD_SEND, WR_RECV, WR_COMMIT: v = 1'b1;
      default:                                        v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// -----------------------------------------------------------------------------
// spi_bit_counter
// Saturating bit counter shared by the address, read and write phases.
// Ports:
//  i_clk   : system clock
//  i_clr   : synchronous clear, has priority over i_inc
//  i_inc   : count strobe (one per SCLK edge of interest)
//  o_done  : count == BITS
//  o_last  : i_inc while count == BITS-1 (the strobe that completes the phase)
// -----------------------------------------------------------------------------
module spi_bit_counter #(
  parameter int BITS  = 8,
  parameter int CNT_W = 4
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_done,
  output logic o_last
);

  logic [CNT_W-1:0] r_count;

  // Count strobes; hold at BITS so a stray strobe can never wrap the count.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_inc && (r_count != CNT_W'(BITS))) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == CNT_W'(BITS));
  // Looking one strobe ahead lets the FSM change state on the very edge
  // that samples the final strobe, keeping the enables one cycle later.
  assign o_last = i_inc && (r_count == CNT_W'(BITS - 1));

endmodule

// File: rtl/spi_fsm.sv
// -----------------------------------------------------------------------------
// spi_fsm
// Control FSM for the SPI slave datapath: one byte of 7-bit address + R/W,
// then one data byte read out or written in.
// Ports:
//  Clk       : system clock, rising edge
//  reset     : synchronous active-high reset
//  cs        : conditioned chip select, active low
//  sclk_pos  : one-cycle strobe on rising SCLK edge
//  sclk_neg  : one-cycle strobe on falling SCLK edge
//  rw_bit    : shift-register bit 0 (1 = read, 0 = write)
//  sr_we     : shift-register parallel-load pulse
//  addr_we   : address-latch enable pulse
//  dm_we     : data-memory write-enable pulse
//  miso_buff : MISO tristate enable (1 = drive)
//  err       : sticky abort flag, only present with SPI_FSM_ERR_EN defined
// Configuration macro: SPI_FSM_ERR_EN (adds the err output).
// -----------------------------------------------------------------------------
module spi_fsm
  import spi_pkg::*;
#(
  parameter int BITS  = SPI_BITS,
  parameter int CNT_W = SPI_CNT_W
) (
  input  logic Clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic sr_we,
  output logic addr_we,
  output logic dm_we,
  output logic miso_buff
`ifdef SPI_FSM_ERR_EN
  ,
  output logic err
`endif
);

  spi_state_t r_state;
  spi_state_t w_next_state;
  logic       w_abort;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_cnt_done;
  logic       w_cnt_last;
  logic       w_phase_end;

  // cs high anywhere outside IDLE wins over every other transition.
  assign w_abort     = cs && (r_state != IDLE);
  assign w_phase_end = w_cnt_last || w_cnt_done;

  // Select which strobe (if any) the current state counts.
  always_comb begin
    w_cnt_inc = 1'b0;
    case (r_state)
      GET, WR_RECV: w_cnt_inc = sclk_pos && !w_abort;
      RD_SEND:      w_cnt_inc = sclk_neg && !w_abort;
      default:      w_cnt_inc = 1'b0;
    endcase
  end

  // Counter is held clear outside the counting states, so every phase starts at 0.
  always_comb begin
    w_cnt_clr = 1'b0;
    case (r_state)
      GET, WR_RECV, RD_SEND: w_cnt_clr = reset || w_abort;
      default:               w_cnt_clr = 1'b1;
    endcase
  end

  spi_bit_counter #(
    .BITS  (BITS),
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk  (Clk),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_done (w_cnt_done),
    .o_last (w_cnt_last)
  );

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (!cs) w_next_state = GET;
        else     w_next_state = IDLE;
      end
      GET: begin
        if (w_phase_end) w_next_state = GOT;
        else             w_next_state = GET;
      end
      GOT: begin
        if (rw_bit == SPI_READ) w_next_state = RD_LOAD;
        else                    w_next_state = WR_RECV;
      end
      RD_LOAD:   w_next_state = RD_SEND;
      RD_SEND: begin
        if (w_phase_end) w_next_state = DONE;
        else             w_next_state = RD_SEND;
      end
      WR_RECV: begin
        if (w_phase_end) w_next_state = WR_COMMIT;
        else             w_next_state = WR_RECV;
      end
      WR_COMMIT: w_next_state = DONE;
      DONE: begin
        if (cs) w_next_state = IDLE;
        else    w_next_state = DONE;
      end
      default:   w_next_state = IDLE;
    endcase
    if (w_abort) begin
      w_next_state = IDLE;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // State register with Moore outputs registered from the state being entered,
  // so each enable is exactly the state it belongs to, with no comb path out.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state   <= IDLE;
      sr_we     <= 1'b0;
      addr_we   <= 1'b0;
      dm_we     <= 1'b0;
      miso_buff <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      sr_we     <= (w_next_state == RD_LOAD);
      addr_we   <= (w_next_state == GOT);
      dm_we     <= (w_next_state == WR_COMMIT);
      miso_buff <= (w_next_state == RD_SEND);
    end
  end

`ifdef SPI_FSM_ERR_EN
  // Sticky abort flag: set on an abort exit, cleared when a new transaction starts.
  always_ff @(posedge Clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (cs && is_abortable(r_state)) begin
      err <= 1'b1;
    end else if ((r_state == IDLE) && !cs) begin
      err <= 1'b0;
    end else begin
      err <= err;
    end
  end
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_fsm
// Directed self-checking bench for spi_fsm: reset, read, write, abort,
// simultaneous events, idle noise and reset during RD_SEND.
// -----------------------------------------------------------------------------
module tb_spi_fsm;
  import spi_pkg::*;

  logic Clk = 1'b0;
  logic reset, cs, sclk_pos, sclk_neg, rw_bit;
  logic sr_we, addr_we, dm_we, miso_buff;
`ifdef SPI_FSM_ERR_EN
  logic err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  spi_fsm dut (
    .Clk       (Clk),
    .reset     (reset),
    .cs        (cs),
    .sclk_pos  (sclk_pos),
    .sclk_neg  (sclk_neg),
    .rw_bit    (rw_bit),
    .sr_we     (sr_we),
    .addr_we   (addr_we),
    .dm_we     (dm_we),
    .miso_buff (miso_buff)
`ifdef SPI_FSM_ERR_EN
    ,
    .err       (err)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One-cycle strobe(s).
  task automatic pulse(input logic p, input logic n);
    sclk_pos = p;
    sclk_neg = n;
    tick();
    sclk_pos = 1'b0;
    sclk_neg = 1'b0;
  endtask

  function automatic logic [7:0] outs();
    return {4'd0, sr_we, addr_we, dm_we, miso_buff};
  endfunction

  function automatic logic [7:0] st();
    return {5'd0, dut.r_state};
  endfunction

  // cs low, then 8 address strobes; returns right after the 8th is sampled.
  task automatic addr_phase(input logic rw);
    cs = 1'b0;
    rw_bit = rw;
    tick();
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1, 1'b0);
      tick();
    end
    pulse(1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
    tick(); tick();
    check("rst_state", st(), {5'd0, IDLE});
    check("rst_outs", outs(), 8'h00);
`ifdef SPI_FSM_ERR_EN
    check("rst_err", {7'd0, err}, 8'h00);
`endif
    reset = 1'b0;
    tick();

    // ---------------- read ----------------
    addr_phase(1'b1);
    check("rd_got_state", st(), {5'd0, GOT});
    check("rd_addr_we", outs(), 8'h04);
    tick();
    check("rd_sr_we", outs(), 8'h08);
    tick();
    check("rd_miso_on", outs(), 8'h01);
    check("rd_send_state", st(), {5'd0, RD_SEND});
    for (int i = 0; i < 7; i++) begin
      pulse(1'b0, 1'b1);
      tick();
      check("rd_miso_hold", outs(), 8'h01);
    end
    pulse(1'b0, 1'b1);
    check("rd_miso_off", outs(), 8'h00);
    check("rd_done_state", st(), {5'd0, DONE});
    pulse(1'b1, 1'b1);
    check("rd_done_ignore", st(), {5'd0, DONE});
    cs = 1'b1;
    tick();
    check("rd_idle_state", st(), {5'd0, IDLE});
    check("rd_idle_outs", outs(), 8'h00);

    // ---------------- write ----------------
    addr_phase(1'b0);
    check("wr_addr_we", outs(), 8'h04);
    tick();
    check("wr_recv_state", st(), {5'd0, WR_RECV});
    check("wr_recv_outs", outs(), 8'h00);
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1, 1'b0);
      tick();
      check("wr_recv_quiet", outs(), 8'h00);
    end
    pulse(1'b1, 1'b0);
    check("wr_dm_we", outs(), 8'h02);
    tick();
    check("wr_dm_we_off", outs(), 8'h00);
    check("wr_done_state", st(), {5'd0, DONE});
    cs = 1'b1;
    tick();
    check("wr_idle_state", st(), {5'd0, IDLE});

    // ---------------- abort in address phase ----------------
    cs = 1'b0;
    rw_bit = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0);
      tick();
    end
    cs = 1'b1;
    tick();
    check("ab_state", st(), {5'd0, IDLE});
    check("ab_outs", outs(), 8'h00);
`ifdef SPI_FSM_ERR_EN
    check("ab_err_set", {7'd0, err}, 8'h01);
`endif
    tick();
    check("ab_no_addr_we", outs(), 8'h00);
`ifdef SPI_FSM_ERR_EN
    check("ab_err_sticky", {7'd0, err}, 8'h01);
`endif
    cs = 1'b0;
    tick();
    check("ab_restart_state", st(), {5'd0, GET});
`ifdef SPI_FSM_ERR_EN
    check("ab_err_clear", {7'd0, err}, 8'h00);
`endif
    cs = 1'b1;
    tick();
    check("ab_idle2", st(), {5'd0, IDLE});

    // ---------------- simultaneous events ----------------
    addr_phase(1'b0);
    tick();
    check("sim_recv_state", st(), {5'd0, WR_RECV});
    pulse(1'b1, 1'b1);
    check("sim_both_one", {4'd0, dut.u_cnt.r_count}, 8'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0);
      tick();
    end
    check("sim_count7", {4'd0, dut.u_cnt.r_count}, 8'd7);
    check("sim_still_recv", st(), {5'd0, WR_RECV});
    cs = 1'b1;
    pulse(1'b1, 1'b0);
    check("sim_abort_state", st(), {5'd0, IDLE});
    check("sim_no_dm_we", outs(), 8'h00);
    tick();
    check("sim_no_dm_we2", outs(), 8'h00);

    // ---------------- idle noise ----------------
    cs = 1'b1;
    for (int i = 0; i < 50; i++) begin
      sclk_pos = 1'($urandom_range(1, 0));
      sclk_neg = 1'($urandom_range(1, 0));
      tick();
      check("noise_state", st(), {5'd0, IDLE});
      check("noise_outs", outs(), 8'h00);
    end
    sclk_pos = 1'b0;
    sclk_neg = 1'b0;

    // ---------------- reset during RD_SEND ----------------
    addr_phase(1'b1);
    tick();
    tick();
    check("rr_miso_on", outs(), 8'h01);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1);
      tick();
    end
    reset = 1'b1;
    tick();
    check("rr_state1", st(), {5'd0, IDLE});
    check("rr_outs1", outs(), 8'h00);
    tick();
    check("rr_state2", st(), {5'd0, IDLE});
    check("rr_outs2", outs(), 8'h00);
    reset = 1'b0;
    cs = 1'b1;
    tick();
    check("rr_idle_after", st(), {5'd0, IDLE});
    check("rr_outs_after", outs(), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_fsm.md
# spi_fsm

Control FSM for the SPI slave datapath. It watches the conditioned chip-select and the SCLK edge strobes from the input conditioners, and counts bits. It drives the enables that sequence the shift register, the address latch, the data memory and the MISO output buffer. Each transaction is one byte: 7-bit address plus a R/W bit, followed by one data byte sent or received.

## Interface
- `BITS`, default 8: bits per phase (address phase and data phase).
- `CNT_W`, default 4: bit-counter width; must satisfy 2^CNT_W > BITS.

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cs`  in  1  conditioned chip select, active low.
- `sclk_pos`  in  1  one-cycle strobe on a rising SCLK edge.
- `sclk_neg`  in  1  one-cycle strobe on a falling SCLK edge.
- `rw_bit`  in  1  shift-register parallel-out bit 0; 1 = read, 0 = write.
- `sr_we`  out  1  shift-register parallel-load pulse.
- `addr_we`  out  1  address-latch enable pulse.
- `dm_we`  out  1  data-memory write-enable pulse.
- `miso_buff`  out  1  MISO tristate enable; 1 = drive.

## Operation
States: IDLE, GET, GOT, RD_LOAD, RD_SEND, WR_RECV, WR_COMMIT, DONE.

- IDLE: counter cleared. Moves to GET when `cs`=0.
- GET: counts `sclk_pos` strobes. When the count reaches `BITS`, moves to GOT.
- GOT: `addr_we`=1 for one cycle.
  - Next state is RD_LOAD if `rw_bit`=1, else WR_RECV.
  - Counter is cleared.
- RD_LOAD: `sr_we`=1 for one cycle, then RD_SEND.
- RD_SEND: `miso_buff`=1 throughout. Counts `sclk_neg` strobes; at `BITS`, moves to DONE.
- WR_RECV: counts `sclk_pos` strobes; at `BITS`, moves to WR_COMMIT.
- WR_COMMIT: `dm_we`=1 for one cycle, then DONE.
- DONE: all outputs 0. Waits for `cs`=1, then IDLE. Strobes are ignored.
- Abort: `cs`=1 in any non-IDLE state returns to IDLE next cycle. This overrides every other transition, including same-cycle strobes. Any pulse due that cycle is suppressed.
- Strobes seen in a state that does not count them are ignored.
- If `sclk_pos` and `sclk_neg` are both high in a cycle, the state uses only the edge it counts.
- The counter saturates at `BITS` and never wraps.
- Outputs are Moore: registered, and a function of state only.

## Timing
- Reset: state IDLE, counter 0, and `sr_we`, `addr_we`, `dm_we`, `miso_buff` all 0. Reset wins over every input, including a reset asserted mid-transaction.
- `addr_we` is high in the cycle after the clock edge that samples the 8th address `sclk_pos`.
- `sr_we` is high exactly one cycle after `addr_we`. This gives the memory's asynchronous read one cycle of settled address.
- `miso_buff` rises in the cycle after `sr_we` and falls in the cycle after the 8th `sclk_neg` is sampled.
- `dm_we` is high in the cycle after the 8th data `sclk_pos` is sampled.
- At most one of `sr_we`, `addr_we`, `dm_we` is high in any cycle.

## Configuration
Macro: `SPI_FSM_ERR_EN`.
- Defined: adds output `err` (1 bit, reset 0).
  - Set in the cycle after an abort, i.e. after leaving any of GET through WR_COMMIT because `cs`=1.
  - Sticky until reset, or until the next IDLE→GET transition clears it.
- Undefined: no `err` port and no extra logic. Abort behaviour is unchanged.

## Structure
- Package `spi_pkg`:
  - State enum `spi_state_t`, 3 bits.
  - Constants `SPI_BITS`=8 and `SPI_CNT_W`=4.
  - Encoding constant for the R/W bit (`SPI_READ`=1).
- One sub-module, `spi_bit_counter`:
  - Inputs: clear, strobe enable.
  - Output: `done` (count == `BITS`).
  - Saturating; synchronous clear that has priority over increment.
  - Instantiated once and reused across phases.
- Everything else (next-state and output decode) lives in `spi_fsm`.

## Test plan
- **Reset:** assert `reset` for 2 cycles during RD_SEND → next cycle state IDLE and all outputs 0; `miso_buff` drops immediately.
- **Read:** `cs`=0, 8 `sclk_pos` with `rw_bit`=1 at GOT → `addr_we` for 1 cycle, `sr_we` the next cycle, `miso_buff`=1 for exactly 8 `sclk_neg` strobes, then DONE. Raising `cs` → IDLE.
- **Write:** same address phase with `rw_bit`=0 → `addr_we`, then 8 `sclk_pos` → `dm_we` high for exactly 1 cycle and `sr_we` never asserted.
- **Abort:** `cs`=1 after the 5th address `sclk_pos` → no `addr_we`, IDLE the next cycle. With `SPI_FSM_ERR_EN`, `err`=1 and it clears on the next `cs` fall.
- **Simultaneous events:** `cs`=1 in the same cycle as the 8th data `sclk_pos` → `dm_we` stays 0. Both strobes high in WR_RECV → exactly one count.
- **Idle noise:** `sclk_pos`/`sclk_neg` toggling with `cs`=1 for 50 cycles → remains IDLE, all outputs 0.
